tft_bus_engine: RTL

- Parametrised 8080-style parallel bus engine for TFT LCD panels (ILI/SSD class) driving RST/BL/CS/RS/WR/RD/DATA.
- Generalises the fixed one-clock-per-phase command/data writer: configurable bus width and WR/RD/reset timing, valid/ready request stream, multi-beat CS bursts, and optional panel read-back.
- Sits between the LCD init/pixel sequencers and the panel pins.

---
 rtl/tft_bus_engine.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tft_bus_engine.sv
// rtl/tft_bus_engine.sv - 8080-style TFT panel bus engine: panel reset, command/data writes, CS bursts
// Panel read-back (op 11) is built only when TFT_BUS_READ_EN is defined.
module tft_bus_engine #(
   parameter int DW           = 16,
   parameter int SETUP_CYC    = 1,
   parameter int WR_LOW_CYC   = 1,
   parameter int WR_HIGH_CYC  = 1,
   parameter int RD_LOW_CYC   = 4,
   parameter int RST_LOW_CYC  = 65535,
   parameter int RST_WAIT_CYC = 65535
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    req_op,
   input  logic [DW-1:0] req_data,
   input  logic          req_last,
   output logic          done,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_data,
   output logic          lcd_rst,
   output logic          lcd_bl,
   output logic          lcd_cs,
   output logic          lcd_rs,
   output logic          lcd_wr,
   output logic          lcd_rd,
   output logic [DW-1:0] lcd_data_o,
   output logic          lcd_data_oe,
   input  logic [DW-1:0] lcd_data_i
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_WR_LO, S_WR_HI, S_RD_LO, S_RD_HI, S_RST_LO, S_RST_WAIT
   } state_t;

   localparam logic [1:0] OP_RST = 2'b00;
   localparam logic [1:0] OP_RD  = 2'b11;

   state_t        r_state, w_state_nxt;
   logic [15:0]   r_cnt, w_cnt_nxt;
   logic          r_last;
   logic          w_accept, w_phase_end;

   logic          r_done, r_lcd_rst, r_lcd_bl, r_lcd_cs, r_lcd_rs, r_lcd_wr;
   logic [DW-1:0] r_lcd_data_o;
   logic          w_done_nxt, w_rst_nxt, w_bl_nxt, w_cs_nxt, w_rs_nxt, w_wr_nxt;
   logic [DW-1:0] w_data_nxt;

   assign req_ready   = (r_state == S_IDLE) && !rst;
   assign w_accept    = req_valid && req_ready;
   assign w_phase_end = (r_cnt == 16'd0);

   // Counter is loaded with (length-1) on phase entry; a phase ends when it reaches zero.
   function automatic logic [15:0] phase_len(input state_t s);
      case (s)
         S_SETUP:    phase_len = 16'(SETUP_CYC - 1);
         S_WR_LO:    phase_len = 16'(WR_LOW_CYC - 1);
         S_WR_HI:    phase_len = 16'(WR_HIGH_CYC - 1);
         S_RD_LO:    phase_len = 16'(RD_LOW_CYC - 1);
         S_RD_HI:    phase_len = 16'(WR_HIGH_CYC - 1);
         S_RST_LO:   phase_len = 16'(RST_LOW_CYC - 1);
         S_RST_WAIT: phase_len = 16'(RST_WAIT_CYC - 1);
         default:    phase_len = 16'd0;
      endcase
   endfunction

`ifdef TFT_BUS_READ_EN
   logic          r_is_rd, w_rd_op;
   logic          r_lcd_rd, r_lcd_data_oe, r_rsp_valid;
   logic [DW-1:0] r_rsp_data;
   logic          w_rd_nxt, w_oe_nxt, w_rsp_valid_nxt;

   assign w_rd_op = w_accept ? (req_op == OP_RD) : r_is_rd;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 16'd0;
         r_last  <= 1'b0;
`ifdef TFT_BUS_READ_EN
         r_is_rd <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_last  <= req_last;
`ifdef TFT_BUS_READ_EN
            r_is_rd <= (req_op == OP_RD);
`endif
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (req_op == OP_RST) begin
                  w_state_nxt = S_RST_LO;
               end else if (req_op == OP_RD) begin
`ifdef TFT_BUS_READ_EN
                  w_state_nxt = S_SETUP;
`else
                  w_state_nxt = S_IDLE;
`endif
               end else begin
                  w_state_nxt = S_SETUP;
               end
            end
         end
         S_SETUP: begin
            if (w_phase_end) begin
`ifdef TFT_BUS_READ_EN
               w_state_nxt = r_is_rd ? S_RD_LO : S_WR_LO;
`else
               w_state_nxt = S_WR_LO;
`endif
            end
         end
         S_WR_LO:    if (w_phase_end) w_state_nxt = S_WR_HI;
         S_WR_HI:    if (w_phase_end) w_state_nxt = S_IDLE;
`ifdef TFT_BUS_READ_EN
         S_RD_LO:    if (w_phase_end) w_state_nxt = S_RD_HI;
         S_RD_HI:    if (w_phase_end) w_state_nxt = S_IDLE;
`endif
         S_RST_LO:   if (w_phase_end) w_state_nxt = S_RST_WAIT;
         S_RST_WAIT: if (w_phase_end) w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase

      if (w_state_nxt != r_state) begin
         w_cnt_nxt = phase_len(w_state_nxt);
      end else if (!w_phase_end) begin
         w_cnt_nxt = r_cnt - 16'd1;
      end else begin
         w_cnt_nxt = r_cnt;
      end
   end

   // Next values of the registered pin/status outputs.
   always_comb begin
      w_rst_nxt  = (w_state_nxt != S_RST_LO);
      w_wr_nxt   = (w_state_nxt != S_WR_LO);
      w_cs_nxt   = r_lcd_cs;
      w_rs_nxt   = r_lcd_rs;
      w_bl_nxt   = r_lcd_bl;
      w_data_nxt = r_lcd_data_o;
      w_done_nxt = 1'b0;

      if (w_accept) begin
         if (req_op == OP_RST) begin
            w_cs_nxt = 1'b1;
            w_bl_nxt = 1'b0;
         end else if (req_op == OP_RD) begin
`ifdef TFT_BUS_READ_EN
            w_cs_nxt = 1'b0;
            w_rs_nxt = 1'b1;
`else
            if (req_last) begin
               w_cs_nxt   = 1'b1;
               w_done_nxt = 1'b1;
            end
`endif
         end else begin
            w_cs_nxt   = 1'b0;
            w_rs_nxt   = req_op[1];
            w_data_nxt = req_data;
         end
      end

      if (w_phase_end && r_last && (r_state == S_WR_HI || r_state == S_RD_HI)) begin
         w_cs_nxt   = 1'b1;
         w_done_nxt = 1'b1;
      end
      if (w_phase_end && r_state == S_RST_WAIT) begin
         w_bl_nxt   = 1'b1;
         w_done_nxt = 1'b1;
      end

`ifdef TFT_BUS_READ_EN
      w_rd_nxt        = (w_state_nxt != S_RD_LO);
      w_oe_nxt        = !(w_rd_op && (w_state_nxt == S_SETUP || w_state_nxt == S_RD_LO));
      w_rsp_valid_nxt = (r_state == S_RD_LO) && w_phase_end;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_done       <= 1'b0;
         r_lcd_rst    <= 1'b1;
         r_lcd_bl     <= 1'b0;
         r_lcd_cs     <= 1'b1;
         r_lcd_rs     <= 1'b1;
         r_lcd_wr     <= 1'b1;
         r_lcd_data_o <= '0;
      end else begin
         r_done       <= w_done_nxt;
         r_lcd_rst    <= w_rst_nxt;
         r_lcd_bl     <= w_bl_nxt;
         r_lcd_cs     <= w_cs_nxt;
         r_lcd_rs     <= w_rs_nxt;
         r_lcd_wr     <= w_wr_nxt;
         r_lcd_data_o <= w_data_nxt;
      end
   end

   assign done       = r_done;
   assign lcd_rst    = r_lcd_rst;
   assign lcd_bl     = r_lcd_bl;
   assign lcd_cs     = r_lcd_cs;
   assign lcd_rs     = r_lcd_rs;
   assign lcd_wr     = r_lcd_wr;
   assign lcd_data_o = r_lcd_data_o;

`ifdef TFT_BUS_READ_EN
   // The panel drives the bus during the last RD-low cycle; capture it at that edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lcd_rd      <= 1'b1;
         r_lcd_data_oe <= 1'b1;
         r_rsp_valid   <= 1'b0;
         r_rsp_data    <= '0;
      end else begin
         r_lcd_rd      <= w_rd_nxt;
         r_lcd_data_oe <= w_oe_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         if (r_state == S_RD_LO && w_phase_end) r_rsp_data <= lcd_data_i;
      end
   end

   assign lcd_rd      = r_lcd_rd;
   assign lcd_data_oe = r_lcd_data_oe;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_data    = r_rsp_data;
`else
   logic w_unused;
   assign w_unused    = ^lcd_data_i;
   assign lcd_rd      = 1'b1;
   assign lcd_data_oe = 1'b1;
   assign rsp_valid   = 1'b0;
   assign rsp_data    = '0;
`endif

endmodule
